// File: rtl/adc_pkg.sv
// adc_pkg - shared types and constants for the dual-channel SPI ADC sampler.
//   state_e      : sequencing FSM states
//   FRAME_PULSES : SCK pulses per conversion frame
//   DATA_FIRST_PULSE : first pulse that carries a data bit (D11)
//   CMD_*        : fixed command bits sent on pulses 1, 2 and 4
//   cmd_bit()    : mosi value for a given pulse number and channel
package adc_pkg;

  localparam int SAMPLE_W         = 12;
  localparam int CNT_W            = 16;
  localparam int PULSE_W          = 5;
  localparam int FRAME_PULSES     = 17;
  localparam int DATA_FIRST_PULSE = 6;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_e;

  // Pulse 3 carries the channel select (ODD); pulses 5 and later send 0.
  function automatic logic cmd_bit(input logic [PULSE_W-1:0] pulse, input logic ch);
    logic b;
    case (pulse)
      5'd1:    b = CMD_START;
      5'd2:    b = CMD_SGL;
      5'd3:    b = ch;
      5'd4:    b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_sampler_avg4.sv
// avg4 - 4-sample moving average for one ADC channel.
// Ports:
//   clk      : system clock
//   reset    : synchronous active-high reset, clears the history to zero
//   sample_i : newest raw 12-bit sample
//   valid_i  : strobe, shifts sample_i into the history
//   avg_o    : (sample_i + last three accepted samples) >> 2, combinational so the
//              caller can register it on the same edge as valid_i
// Only instantiated when ADC_AVG_EN is defined.
module avg4
  import adc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  output logic [SAMPLE_W-1:0] avg_o
);

  logic [SAMPLE_W-1:0] h0_q, h1_q, h2_q;
  logic [SAMPLE_W+1:0] sum;

  assign sum   = {2'b00, sample_i} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
  assign avg_o = sum[SAMPLE_W+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else if (valid_i) begin
      h2_q <= h1_q;
      h1_q <= h0_q;
      h0_q <= sample_i;
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler - sequences a dual-channel 12-bit SPI ADC, alternating channel 0
// and channel 1 frames, and publishes both results together once per pair.
// Parameters:
//   CLK_DIV    : clk cycles per SCK half-period (2..255)
//   GAP_CYCLES : idle clk cycles between frames (>= 1)
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   en         : run enable
//   miso       : ADC serial data
//   sck        : SPI clock, idles low
//   cs_n       : ADC chip select, active low
//   mosi       : ADC command bits
//   p1data     : latest channel-0 result
//   p2data     : latest channel-1 result
//   data_valid : one-cycle pulse when p1data/p2data update
// Build option: define ADC_AVG_EN to publish 4-sample moving averages instead
// of raw samples.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cs_n high, sck low, waiting for en
// CS_SETUP | cs_n low for CLK_DIV cycles, mosi = start bit
// SHIFT    | 17 SCK pulses; command out, 12 data bits in
// CS_HOLD  | cs_n still low, sck low for CLK_DIV cycles after last fall
// GAP      | cs_n high for GAP_CYCLES; results publish on entry after ch1
module adc_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                miso,
  output logic                sck,
  output logic                cs_n,
  output logic                mosi,
  output logic [SAMPLE_W-1:0] p1data,
  output logic [SAMPLE_W-1:0] p2data,
  output logic                data_valid
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic [PULSE_W-1:0]  pulse_q, pulse_d;
  logic                sck_q, sck_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic                ch_q, ch_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] p1_q, p1_d;
  logic [SAMPLE_W-1:0] p2_q, p2_d;
  logic                dv_q, dv_d;

  logic                div_tc;
  logic [PULSE_W-1:0]  pulse_nxt;
  logic                pair_done;
  logic [SAMPLE_W-1:0] ch0_out, ch1_out;

  assign div_tc    = (div_q == '0);
  assign pulse_nxt = pulse_q + 5'd1;

`ifdef ADC_AVG_EN
  avg4 u_avg_ch0 (
    .clk      (clk),
    .reset    (reset),
    .sample_i (hold_q),
    .valid_i  (pair_done),
    .avg_o    (ch0_out)
  );

  avg4 u_avg_ch1 (
    .clk      (clk),
    .reset    (reset),
    .sample_i (sh_q),
    .valid_i  (pair_done),
    .avg_o    (ch1_out)
  );
`else
  assign ch0_out = hold_q;
  assign ch1_out = sh_q;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pulse_d   = pulse_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ch_d      = ch_q;
    sh_d      = sh_q;
    hold_d    = hold_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    dv_d      = 1'b0;
    pair_done = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        ch_d   = 1'b0;
        if (en) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = cmd_bit(5'd1, 1'b0);
          pulse_d = 5'd1;
          div_d   = DIV_LOAD;
        end
      end

      CS_SETUP: begin
        if (div_tc) begin
          state_d = SHIFT;
          sck_d   = 1'b1;
          div_d   = DIV_LOAD;
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      SHIFT: begin
        if (sck_q) begin
          if (div_tc) begin
            sck_d = 1'b0;
            div_d = DIV_LOAD;
          end else begin
            div_d = div_q - CNT_W'(1);
          end
        end else begin
          // Registered from the low phase only, so mosi moves one clk after
          // the falling edge and is settled well before the next rise.
          mosi_d = cmd_bit(pulse_nxt, ch_q);
          if (div_tc) begin
            div_d = DIV_LOAD;
            if (pulse_q == PULSE_W'(FRAME_PULSES)) begin
              state_d = CS_HOLD;
            end else begin
              pulse_d = pulse_nxt;
              sck_d   = 1'b1;
              if (pulse_nxt >= PULSE_W'(DATA_FIRST_PULSE)) begin
                sh_d = {sh_q[SAMPLE_W-2:0], miso};
              end
            end
          end else begin
            div_d = div_q - CNT_W'(1);
          end
        end
      end

      CS_HOLD: begin
        if (div_tc) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          div_d   = GAP_LOAD;
          if (ch_q) begin
            pair_done = 1'b1;
            p1_d      = ch0_out;
            p2_d      = ch1_out;
            dv_d      = 1'b1;
            ch_d      = 1'b0;
          end else begin
            hold_d = sh_q;
            ch_d   = 1'b1;
          end
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (div_tc) begin
          // A pending channel-1 frame always runs so pairs never split.
          if (ch_q || en) begin
            state_d = CS_SETUP;
            cs_n_d  = 1'b0;
            mosi_d  = cmd_bit(5'd1, ch_q);
            pulse_d = 5'd1;
            div_d   = DIV_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      pulse_q <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ch_q    <= 1'b0;
      sh_q    <= '0;
      hold_q  <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pulse_q <= pulse_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ch_q    <= ch_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      dv_q    <= dv_d;
    end
  end

  assign sck        = sck_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;
  assign p1data     = p1_q;
  assign p2data     = p2_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler - bench for adc_sampler with CLK_DIV=2, GAP_CYCLES=4.
// An ADC model answers each frame with the word for the channel selected by the
// ODD command bit; expected pair results are queued when a pair's stimulus is
// set and compared when data_valid pulses.
module tb_adc_sampler;

  localparam int CLK_DIV       = 2;
  localparam int GAP_CYCLES    = 4;
  localparam int CS_LOW_CYCLES = 36 * CLK_DIV;
  localparam int PAIR_BUDGET   = 400;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic        miso  = 1'b0;
  logic        sck, cs_n, mosi, data_valid;
  logic [11:0] p1data, p2data;

  always #5 clk = ~clk;

  adc_sampler #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .miso       (miso),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .p1data     (p1data),
    .p2data     (p2data),
    .data_valid (data_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ADC model ----------------
  logic [11:0] v0 = 12'h000;
  logic [11:0] v1 = 12'h000;
  logic [11:0] word;
  logic        ch_sel    = 1'b0;
  logic [3:0]  cmd       = 4'h0;
  logic        mosi_rise = 1'b0;
  logic        exp_ch    = 1'b0;
  logic        prev_cs   = 1'b1;
  logic        prev_sck  = 1'b0;
  int          pcnt         = 0;
  int          frame_starts = 0;
  int          cs_low_cnt   = 0;

  always @(negedge clk) begin
    if (cs_n === 1'b0) cs_low_cnt++;
    else cs_low_cnt = 0;
  end

  always @(cs_n or sck) begin
    if (reset === 1'b0) begin
      if (cs_n !== prev_cs) begin
        if (cs_n === 1'b0) begin
          pcnt = 0;
          cmd  = 4'h0;
          miso = 1'b0;
          frame_starts++;
        end else if (cs_n === 1'b1) begin
          check_eq("cs_low_cycles", cs_low_cnt, CS_LOW_CYCLES);
          check_eq("sck_pulses", pcnt, 17);
          check_eq(exp_ch ? "cmd_ch1" : "cmd_ch0", {28'h0, cmd}, exp_ch ? 32'hF : 32'hD);
          exp_ch = ~exp_ch;
        end
      end
      if (sck !== prev_sck && cs_n === 1'b0) begin
        if (sck === 1'b1) begin
          pcnt++;
          if (pcnt <= 4) cmd = {cmd[2:0], mosi};
          if (pcnt == 3) ch_sel = mosi;
          mosi_rise = mosi;
        end else begin
          check_eq("mosi_hold", {31'h0, mosi}, {31'h0, mosi_rise});
          word = ch_sel ? v1 : v0;
          if (pcnt >= 5 && pcnt <= 16) miso = word[16-pcnt];
          else miso = 1'b0;
        end
      end
    end else begin
      exp_ch = 1'b0;
    end
    prev_cs  = cs_n;
    prev_sck = sck;
  end

  // ---------------- scoreboard ----------------
  logic [23:0] sb[$];
  logic [23:0] sb_exp;
  logic [23:0] last_exp = 24'h0;
  logic        dv_prev  = 1'b0;

`ifdef ADC_AVG_EN
  logic [11:0] h0[3];
  logic [11:0] h1[3];
  initial begin
    for (int i = 0; i < 3; i++) begin
      h0[i] = 12'h0;
      h1[i] = 12'h0;
    end
  end
`endif

  task automatic clear_hist();
`ifdef ADC_AVG_EN
    for (int i = 0; i < 3; i++) begin
      h0[i] = 12'h0;
      h1[i] = 12'h0;
    end
`endif
  endtask

  task automatic push_pair(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] e0, e1;
`ifdef ADC_AVG_EN
    logic [13:0] s0, s1;
    s0 = {2'b00, a} + {2'b00, h0[0]} + {2'b00, h0[1]} + {2'b00, h0[2]};
    s1 = {2'b00, b} + {2'b00, h1[0]} + {2'b00, h1[1]} + {2'b00, h1[2]};
    e0 = s0[13:2];
    e1 = s1[13:2];
    h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = a;
    h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = b;
`else
    e0 = a;
    e1 = b;
`endif
    v0 = a;
    v1 = b;
    sb.push_back({e0, e1});
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      check_eq("dv_width", {31'h0, dv_prev}, 32'h0);
      if (sb.size() == 0) begin
        check_eq("dv_unexpected", {31'h0, data_valid}, 32'h0);
      end else begin
        sb_exp = sb.pop_front();
        last_exp = sb_exp;
        check_eq("p1data", {20'h0, p1data}, {20'h0, sb_exp[23:12]});
        check_eq("p2data", {20'h0, p2data}, {20'h0, sb_exp[11:0]});
      end
    end
    dv_prev = data_valid;
  end

  // ---------------- helpers ----------------
  task automatic wait_dv(input int budget);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (data_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) check_eq("dv_timeout", {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_pulse(input logic ch, input int p, input int budget);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      if (cs_n === 1'b0 && exp_ch === ch && pcnt == p) hit = 1'b1;
    end
    if (!hit) check_eq("pulse_timeout", {31'h0, hit}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [11:0] tbl0[4] = '{12'h7FF, 12'hABC, 12'h000, 12'h800};
  logic [11:0] tbl1[4] = '{12'h123, 12'h456, 12'hFFF, 12'h001};
  int          starts_before;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", {31'h0, cs_n}, 32'h1);
    check_eq("rst_sck", {31'h0, sck}, 32'h0);
    check_eq("rst_mosi", {31'h0, mosi}, 32'h0);
    check_eq("rst_p1data", {20'h0, p1data}, 32'h0);
    check_eq("rst_p2data", {20'h0, p2data}, 32'h0);
    check_eq("rst_dv", {31'h0, data_valid}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("idle_wait_cs_n", {31'h0, cs_n}, 32'h1);
    check_eq("idle_wait_sck", {31'h0, sck}, 32'h0);

    // Continuous pairs
    for (int i = 0; i < 4; i++) begin
      push_pair(tbl0[i], tbl1[i]);
      if (i == 0) en = 1'b1;
      wait_dv(PAIR_BUDGET);
    end

    // Drop en during channel-0 SHIFT: pair completes, then IDLE
    push_pair(12'h5A5, 12'h3C3);
    wait_pulse(1'b0, 2, PAIR_BUDGET);
    en = 1'b0;
    wait_dv(PAIR_BUDGET);
    starts_before = frame_starts;
    repeat (200) @(negedge clk);
    check_eq("idle_frames", frame_starts - starts_before, 0);
    check_eq("idle_cs_n", {31'h0, cs_n}, 32'h1);
    check_eq("idle_sck", {31'h0, sck}, 32'h0);
    check_eq("idle_hold_p1", {20'h0, p1data}, {20'h0, last_exp[23:12]});
    check_eq("idle_hold_p2", {20'h0, p2data}, {20'h0, last_exp[11:0]});

    // Restart from IDLE
    push_pair(12'h0F0, 12'hE1E);
    en = 1'b1;
    wait_dv(PAIR_BUDGET);

    // Reset during channel-1 pulse 10
    push_pair(12'h321, 12'hCDE);
    wait_pulse(1'b1, 10, PAIR_BUDGET);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_cs_n", {31'h0, cs_n}, 32'h1);
    check_eq("abort_sck", {31'h0, sck}, 32'h0);
    check_eq("abort_p1data", {20'h0, p1data}, 32'h0);
    check_eq("abort_p2data", {20'h0, p2data}, 32'h0);
    check_eq("abort_dv", {31'h0, data_valid}, 32'h0);
    sb.delete();
    clear_hist();
    push_pair(12'hFFF, 12'hFFF);
    @(negedge clk);
    reset = 1'b0;

    // Full-scale pairs after reset (averaging ramp when enabled)
    for (int i = 0; i < 5; i++) begin
      wait_dv(PAIR_BUDGET);
      if (i < 4) push_pair(12'hFFF, 12'hFFF);
      else en = 1'b0;
    end
    repeat (100) @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);
    check_eq("end_cs_n", {31'h0, cs_n}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
